mux_2by1_inout_5bit: RTL and testbench

//   Registered 2:1 multiplexer for 5-bit register-address fields in the datapath.

---
 rtl/mux_2by1_inout_5bit.sv | 35 +++
 tb/tb_mux_2by1_inout_5bit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mux_2by1_inout_5bit.sv
// Registered 2:1 mux for register-address fields, steered by the datapath control word.
// One control bit picks input1/input2; another freezes the output register.
module mux_2by1_inout_5bit #(
    parameter int WIDTH    = 5,
    parameter int CTRL_W   = 18,
    parameter int SEL_BIT  = 2,
    parameter int HOLD_BIT = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  input1,
    input  logic [WIDTH-1:0]  input2,
    input  logic [CTRL_W-1:0] select,
    output logic [WIDTH-1:0]  out,
    output logic              valid
);

    logic sel_bit;
    logic hold_bit;

    assign sel_bit  = select[SEL_BIT];
    assign hold_bit = select[HOLD_BIT];

    // An unknown sel_bit merges the two inputs bitwise, so X is not masked
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out   <= '0;
            valid <= 1'b0;
        end else if (!hold_bit) begin
            out   <= sel_bit ? input2 : input1;
            valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mux_2by1_inout_5bit.sv
// Directed bench for mux_2by1_inout_5bit: reset, select decode, hold, async reset override.
module tb_mux_2by1_inout_5bit;

    logic        clk;
    logic        rst;
    logic [4:0]  input1;
    logic [4:0]  input2;
    logic [17:0] select;
    logic [4:0]  out;
    logic        valid;

    int checks;
    int errors;

    mux_2by1_inout_5bit dut (
        .clk    (clk),
        .rst    (rst),
        .input1 (input1),
        .input2 (input2),
        .select (select),
        .out    (out),
        .valid  (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [4:0] exp_out, input logic exp_valid);
        checks++;
        assert (out === exp_out) else begin
            errors++;
            $error("FAIL %s out: observed %h expected %h", tag, out, exp_out);
        end
        checks++;
        assert (valid === exp_valid) else begin
            errors++;
            $error("FAIL %s valid: observed %b expected %b", tag, valid, exp_valid);
        end
    endtask

    // advance one rising edge and settle 1 time unit past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        input1 = 5'd3;
        input2 = 5'd4;
        select = 18'd4;
        rst    = 1'b1;
        #1;
        check("reset_async", 5'd0, 1'b0);
        step();
        check("reset_held_edge", 5'd0, 1'b0);

        rst = 1'b0;
        #1;
        check("reset_release_noedge", 5'd0, 1'b0);

        // hold straight after reset: valid must stay low
        select = 18'h20000;
        input1 = 5'd7;
        step();
        check("hold_after_reset", 5'd0, 1'b0);

        input1 = 5'd1;
        input2 = 5'd2;
        select = 18'd4;
        step();
        check("sel_input2", 5'd2, 1'b1);

        select = 18'd0;
        step();
        check("sel_input1", 5'd1, 1'b1);

        // inputs change without an edge: out must not follow
        input1 = 5'd9;
        #2;
        check("no_comb_path", 5'd1, 1'b1);

        select = 18'h0FFFB;
        input1 = 5'h1F;
        input2 = 5'h00;
        step();
        check("other_bits_ignored", 5'h1F, 1'b1);

        input2 = 5'h15;
        select = 18'h0FFFF;
        step();
        check("full_width_input2", 5'h15, 1'b1);

        input1 = 5'd1;
        input2 = 5'd2;
        select = 18'd4;
        step();
        check("load_before_hold", 5'd2, 1'b1);

        select = 18'h20000;
        input1 = 5'd7;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_sel0", 5'd2, 1'b1);
        end
        select = 18'h20004;
        input2 = 5'd3;
        step();
        check("hold_sel1", 5'd2, 1'b1);

        input2 = 5'd9;
        select = 18'd4;
        step();
        check("steady_load", 5'd9, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        check("reset_midcycle", 5'd0, 1'b0);
        step();
        check("reset_over_load", 5'd0, 1'b0);
        #3;
        rst = 1'b0;
        #1;
        check("release_noedge", 5'd0, 1'b0);
        step();
        check("reload_after_reset", 5'd9, 1'b1);

        // reset while holding must still clear
        select = 18'h20004;
        step();
        check("hold_before_reset", 5'd9, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        check("reset_over_hold", 5'd0, 1'b0);
        #3;
        rst = 1'b0;
        step();
        check("hold_after_reset2", 5'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
